keypad_scanner: RTL and testbench

- Input-side counterpart to the seven-segment display scanner: instead of strobing anodes to drive digits, it strobes keypad columns and reads rows.
- Scans a 4x4 matrix keypad (Pmod KYPD style), debounces, and reports a single 4-bit hex key code with a one-cycle valid strobe.
- Sits between the board I/O pins and the ALU/display logic, supplying operand/OP entry from a keypad.

---
 rtl/kypd_pkg.sv | 34 +++
 rtl/kypd_debounce.sv | 94 +++++++++
 rtl/keypad_scanner.sv | 126 ++++++++++++
 tb/tb_keypad_scanner.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package kypd_pkg;

   // Debounce FSM states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2,
      DEB_REL   = 2'd3
   } kypd_state_e;

   // Result of examining one complete scan frame.
   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } frame_class_e;

   // First column strobed after reset (active-low, one-cold).
   localparam logic [3:0] COL_RESET = 4'b1110;

   // Key index is {row, col}; entry 0 is the top-left key.
   localparam logic [15:0][3:0] KEY_CODE_LUT = {
      4'hD, 4'hE, 4'hF, 4'h0,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic [3:0] keyCode(input logic [3:0] idx);
      return KEY_CODE_LUT[idx];
   endfunction

endpackage

// File: rtl/kypd_debounce.sv
// Frame-level debouncer: accepts a press or release only after
// DEBOUNCE_FRAMES consecutive agreeing frames, and reports the key.
module kypd_debounce
   import kypd_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 4
)
(
   input  logic         clock,
   input  logic         reset_n,
   input  logic         frameDone_i,
   input  frame_class_e frameClass_i,
   input  logic [3:0]   keyIdx_i,
   output logic [3:0]   keyCode_o,
   output logic         keyValid_o,
   output logic         keyHeld_o
);

   localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_FRAMES);

   kypd_state_e state_q;
   logic [3:0]  cnt_q;
   logic [3:0]  cand_q;
   logic [3:0]  keyCode_q;
   logic        keyValid_q;
   logic        keyHeld_q;
   logic [3:0]  cntInc;

   assign cntInc = cnt_q + 4'd1;

   // Debounce FSM; only a classified frame can move it, and every output is registered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         cand_q     <= 4'd0;
         keyCode_q  <= 4'd0;
         keyValid_q <= 1'b0;
         keyHeld_q  <= 1'b0;
      end else begin
         keyValid_q <= 1'b0;
         if (frameDone_i) begin
            case (state_q)
               IDLE: begin
                  if (frameClass_i == SINGLE) begin
                     state_q <= DEB_PRESS;
                     cand_q  <= keyIdx_i;
                     cnt_q   <= 4'd1;
                  end
               end
               DEB_PRESS: begin
                  if (frameClass_i == SINGLE && keyIdx_i == cand_q) begin
                     cnt_q <= cntInc;
                     if (cntInc == DEB_LIMIT) begin
                        state_q    <= HELD;
                        keyCode_q  <= keyCode(cand_q);
                        keyValid_q <= 1'b1;
                        keyHeld_q  <= 1'b1;
                     end
                  end else if (frameClass_i == SINGLE) begin
                     cand_q <= keyIdx_i;
                     cnt_q  <= 4'd1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               HELD: begin
                  if (frameClass_i == NONE) begin
                     state_q <= DEB_REL;
                     cnt_q   <= 4'd1;
                  end
               end
               DEB_REL: begin
                  if (frameClass_i == NONE) begin
                     cnt_q <= cntInc;
                     if (cntInc == DEB_LIMIT) begin
                        state_q   <= IDLE;
                        keyHeld_q <= 1'b0;
                     end
                  end else begin
                     state_q <= HELD;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign keyCode_o  = keyCode_q;
   assign keyValid_o = keyValid_q;
   assign keyHeld_o  = keyHeld_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: strobes columns, samples rows into a per-frame map,
// classifies each frame and hands it to the debouncer.
module keypad_scanner
   import kypd_pkg::*;
#(
   parameter int SCAN_BITS       = 17,
   parameter int DEBOUNCE_FRAMES = 4
)
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   logic [SCAN_BITS-1:0] prescaler_q;
   logic [1:0]           colIdx_q;
   logic [3:0]           col_q;
   logic [3:0]           rowMeta_q;
   logic [3:0]           rowSync_q;
   logic [15:0]          map_q;
   logic [15:0]          map_d;
   logic                 frameDone_q;
   frame_class_e         frameClass_q;
   logic [3:0]           singleIdx_q;
   logic                 tick;
   logic                 lastCol;
   logic [4:0]           onesCount;
   logic [3:0]           singleIdx;
   frame_class_e         frameClass;

   assign tick    = &prescaler_q;
   assign lastCol = (colIdx_q == 2'd3);

   // Two-flop synchronizer for the asynchronous row pins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rowMeta_q <= 4'b1111;
         rowSync_q <= 4'b1111;
      end else begin
         rowMeta_q <= row;
         rowSync_q <= rowMeta_q;
      end
   end

   // Free-running prescaler; each tick ends a column period and advances the strobe.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prescaler_q <= '0;
         colIdx_q    <= 2'd0;
         col_q       <= COL_RESET;
      end else begin
         prescaler_q <= prescaler_q + SCAN_BITS'(1);
         if (tick) begin
            colIdx_q <= colIdx_q + 2'd1;
            col_q    <= {col_q[2:0], col_q[3]};
         end
      end
   end

   // Next map: cleared once a frame has been classified, then the current column is
   // sampled at the end of its period so the rows have fully settled.
   always_comb begin
      map_d = frameDone_q ? '0 : map_q;
      if (tick) begin
         for (int r = 0; r < 4; r++) begin
            map_d[{r[1:0], colIdx_q}] = ~rowSync_q[r];
         end
      end
   end

   // Count pressed keys in the completed map; more than one is treated as ghosting.
   always_comb begin
      onesCount = 5'd0;
      singleIdx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (map_d[i]) begin
            onesCount = onesCount + 5'd1;
            singleIdx = 4'(i);
         end
      end
      if (onesCount == 5'd0) begin
         frameClass = NONE;
      end else if (onesCount == 5'd1) begin
         frameClass = SINGLE;
      end else begin
         frameClass = MULTI;
      end
   end

   // Hold the frame map and register the classification at the last column's tick.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         map_q        <= '0;
         frameDone_q  <= 1'b0;
         frameClass_q <= NONE;
         singleIdx_q  <= 4'd0;
      end else begin
         map_q       <= map_d;
         frameDone_q <= tick && lastCol;
         if (tick && lastCol) begin
            frameClass_q <= frameClass;
            singleIdx_q  <= singleIdx;
         end
      end
   end

   kypd_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
   ) u_debounce (
      .clock        (clock),
      .reset_n      (reset_n),
      .frameDone_i  (frameDone_q),
      .frameClass_i (frameClass_q),
      .keyIdx_i     (singleIdx_q),
      .keyCode_o    (key_code),
      .keyValid_o   (key_valid),
      .keyHeld_o    (key_held)
   );

   assign col = col_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model, a frame-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_keypad_scanner;

   localparam int SCAN_BITS = 2;
   localparam int DF        = 4;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys = '0;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   int codeTab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

   logic [15:0] frameKeys = '0;
   logic        mHeld     = 1'b0;
   logic        mPulse    = 1'b0;
   logic [3:0]  mCode     = 4'd0;
   int          mStreak   = 0;
   int          mCand     = 0;
   int          mRel      = 0;

   keypad_scanner #(
      .SCAN_BITS       (SCAN_BITS),
      .DEBOUNCE_FRAMES (DF)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // 100 MHz clock.
   always #5 clock = ~clock;

   // Keypad matrix: a row is pulled low while any pressed key on it has its column strobed.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         if (|(keys[r*4 +: 4] & ~col)) row[r] = 1'b0;
      end
   end

   // Clocks elapsed since reset was released.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] keySet);
      keys = keySet;
   endtask

   task automatic waitCyc(input int target);
      int guard;
      guard = 0;
      while (cyc != target && guard < 2000) begin
         @(negedge clock);
         guard++;
      end
      if (cyc != target) begin
         checks++;
         errors++;
         $display("[TB] FAIL waitCyc: reached %0d expected %0d", cyc, target);
      end
   endtask

   // Reference model: column k/4 mod 4 is strobed; a frame ends every 16 clocks and
   // its verdict shows up 2 clocks after its last column tick.
   always @(negedge clock) begin
      logic [3:0] expCol;
      int         n;
      int         idx;
      if (!reset_n) begin
         mHeld   = 1'b0;
         mPulse  = 1'b0;
         mCode   = 4'd0;
         mStreak = 0;
         mCand   = 0;
         mRel    = 0;
         checkOutput("rst_col", col, 4'b1110);
         checkOutput("rst_valid", key_valid, 1'b0);
         checkOutput("rst_held", key_held, 1'b0);
         checkOutput("rst_code", key_code, 4'd0);
      end else begin
         mPulse = 1'b0;
         if (cyc % 16 == 15) frameKeys = keys;
         if (cyc >= 17 && cyc % 16 == 1) begin
            n   = $countones(frameKeys);
            idx = 0;
            for (int i = 0; i < 16; i++) if (frameKeys[i]) idx = i;
            if (!mHeld) begin
               if (n == 1) begin
                  if (mStreak > 0 && idx == mCand) mStreak++;
                  else begin
                     mCand   = idx;
                     mStreak = 1;
                  end
                  if (mStreak == DF) begin
                     mHeld   = 1'b1;
                     mPulse  = 1'b1;
                     mCode   = 4'(codeTab[idx]);
                     mStreak = 0;
                  end
               end else begin
                  mStreak = 0;
               end
            end else begin
               if (n == 0) begin
                  mRel++;
                  if (mRel == DF) begin
                     mHeld = 1'b0;
                     mRel  = 0;
                  end
               end else begin
                  mRel = 0;
               end
            end
         end
         expCol = ~(4'b0001 << ((cyc / 4) % 4));
         checkOutput("col", col, expCol);
         checkOutput("key_valid", key_valid, mPulse);
         checkOutput("key_held", key_held, mHeld);
         checkOutput("key_code", key_code, mCode);
      end
   end

   // Directed scenarios, each frame boundary at a multiple of 16 clocks.
   initial begin
      $display("[TB] start");
      repeat (3) @(negedge clock);
      #1 reset_n = 1'b1;

      // clean press of (1,1)
      applyStimulus(16'h0020);
      waitCyc(4);   checkOutput("lit_col1", col, 4'b1101);
      waitCyc(8);   checkOutput("lit_col2", col, 4'b1011);
      waitCyc(12);  checkOutput("lit_col3", col, 4'b0111);
      waitCyc(16);  checkOutput("lit_col0", col, 4'b1110);
      waitCyc(64);  checkOutput("lit_early_valid", key_valid, 1'b0);
      waitCyc(65);  checkOutput("lit_valid5", key_valid, 1'b1);
      checkOutput("lit_code5", key_code, 4'h5);
      checkOutput("lit_held5", key_held, 1'b1);
      waitCyc(66);  checkOutput("lit_pulse_one", key_valid, 1'b0);
      checkOutput("lit_held_on", key_held, 1'b1);

      // release, then bouncy press of (2,2)
      waitCyc(128); applyStimulus(16'h0000);
      waitCyc(192); checkOutput("lit_held_before_rel", key_held, 1'b1);
      applyStimulus(16'h0400);
      waitCyc(193); checkOutput("lit_held_released", key_held, 1'b0);
      waitCyc(224); applyStimulus(16'h0000);
      waitCyc(240); applyStimulus(16'h0400);
      waitCyc(289); checkOutput("lit_bounce_novalid", key_valid, 1'b0);
      waitCyc(304); applyStimulus(16'h0000);
      waitCyc(305); checkOutput("lit_valid9", key_valid, 1'b1);
      checkOutput("lit_code9", key_code, 4'h9);

      // release with a two-frame glitch
      waitCyc(336); applyStimulus(16'h0400);
      waitCyc(337); checkOutput("lit_held_deb_rel", key_held, 1'b1);
      waitCyc(353); checkOutput("lit_glitch_novalid", key_valid, 1'b0);
      checkOutput("lit_glitch_held", key_held, 1'b1);
      waitCyc(368); applyStimulus(16'h0000);
      waitCyc(432); checkOutput("lit_held_last", key_held, 1'b1);
      applyStimulus(16'h8000);
      waitCyc(433); checkOutput("lit_held_drop", key_held, 1'b0);
      waitCyc(497); checkOutput("lit_validD", key_valid, 1'b1);
      checkOutput("lit_codeD", key_code, 4'hD);

      // two keys on one row: ghosting, never accepted
      waitCyc(512); applyStimulus(16'h0000);
      waitCyc(576); applyStimulus(16'h0003);
      waitCyc(577); checkOutput("lit_idle_again", key_held, 1'b0);
      waitCyc(704); checkOutput("lit_multi_held", key_held, 1'b0);
      checkOutput("lit_multi_code", key_code, 4'hD);

      // reset during press debounce of (0,2)
      applyStimulus(16'h0004);
      waitCyc(754);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("lit_rst_col", col, 4'b1110);
      checkOutput("lit_rst_valid", key_valid, 1'b0);
      checkOutput("lit_rst_held", key_held, 1'b0);
      checkOutput("lit_rst_code", key_code, 4'd0);
      repeat (3) @(negedge clock);
      #1 reset_n = 1'b1;
      waitCyc(64);  checkOutput("lit_redeb_early", key_valid, 1'b0);
      waitCyc(65);  checkOutput("lit_redeb_valid", key_valid, 1'b1);
      checkOutput("lit_redeb_code", key_code, 4'h3);
      waitCyc(96);  applyStimulus(16'h0000);
      waitCyc(170); checkOutput("lit_final_held", key_held, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
